// File: rtl/demux.sv
// demux: steers one valid/ready stream to one of 2**SELECT_LINES lanes; packets stay whole on one lane.
// Latency: one cycle from an accepted beat to out_valid on the target lane.
// Backpressure: in_ready = target slot empty or draining this cycle; other lanes drain independently.
module demux #(
    parameter int SELECT_LINES = 2,
    parameter int DATA_WIDTH   = 8,
    localparam int N           = 2**SELECT_LINES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [SELECT_LINES-1:0] in_select,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH*N-1:0] out_data,
    output logic [N-1:0]            out_last,
    output logic [N-1:0]            out_valid,
    input  logic [N-1:0]            out_ready,
    output logic                    busy
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] dat;
    } slot_t;

    state_t                  state_q, state_d;
    logic [SELECT_LINES-1:0] lock_sel_q, lock_sel_d;
    logic [SELECT_LINES-1:0] target;
    logic                    accept;
    logic [N-1:0]            wr_en;
    logic [N-1:0]            full_q;
    slot_t                   slot_q [N];

    // Destination is only sampled from in_select while no packet is open.
    always_comb begin
        target   = (state_q == LOCKED) ? lock_sel_q : in_select;
        in_ready = ~full_q[target] | out_ready[target];
        accept   = in_valid & in_ready;
        wr_en    = '0;
        if (accept) begin
            wr_en[target] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        case (state_q)
            IDLE: begin
                if (accept && !in_last) begin
                    state_d    = LOCKED;
                    lock_sel_d = in_select;
                end
            end
            LOCKED: begin
                if (accept && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    // A refill in the same cycle as a drain keeps the slot full with the new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_en[i]) begin
                    slot_q[i] <= '{last: in_last, dat: in_data};
                    full_q[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign out_data[DATA_WIDTH*g +: DATA_WIDTH] = slot_q[g].dat;
        assign out_last[g]                          = slot_q[g].last;
    end

    assign out_valid = full_q;
    assign busy      = (state_q == LOCKED);

endmodule
